// File: rtl/sum_window_pkg.sv
// Shared types and constants for the sum_window block.
package sum_window_pkg;
  localparam int WIN_DEF = 4;
  localparam int OW_DEF  = 12;
  localparam int DW      = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/sum_window_sat_add.sv
// Accumulator adder: OW-bit running total plus one DW-bit sample.
// Saturating at 2^OW-1 when SUM_WINDOW_SAT_EN is defined, wrapping otherwise.
module sat_add
  import sum_window_pkg::*;
#(
  parameter int OW = OW_DEF
) (
  input  logic [OW-1:0] acc,
  input  logic [DW-1:0] x,
  output logic [OW-1:0] res,
  output logic          clip
);
`ifdef SUM_WINDOW_SAT_EN
  logic [OW:0] wide;

  // The carry out of the OW-bit sum is exactly the clip condition.
  assign wide = {1'b0, acc} + (OW + 1)'(x);
  assign clip = wide[OW];
  assign res  = clip ? '1 : wide[OW-1:0];
`else
  assign res  = acc + OW'(x);
  assign clip = 1'b0;
`endif
endmodule

// File: rtl/sum_window.sv
// Sums WIN consecutive valid samples and offers each total through a one-slot
// valid/ready output; SUM_WINDOW_SAT_EN selects saturating accumulation.
module sum_window
  import sum_window_pkg::*;
#(
  parameter int WIN = WIN_DEF,
  parameter int OW  = OW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] x,
  input  logic          clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] sum,
  output logic          ovf,
  output logic          sat
);
  state_t        state;
  state_t        state_nxt;
  logic [OW-1:0] acc;
  logic [5:0]    cnt;
  logic          acc_sat;
  logic [OW-1:0] add_res;
  logic          add_clip;
  logic          win_sat;
  logic          last;
  logic          complete;
  logic          load;
  logic          drop;

  sat_add #(.OW(OW)) u_add (
    .acc  (acc),
    .x    (x),
    .res  (add_res),
    .clip (add_clip)
  );

  // A clip anywhere in the window marks the whole window total as clipped.
  assign win_sat   = acc_sat | add_clip;
  assign last      = (cnt == 6'(WIN - 1));
  assign complete  = in_valid && !clr && last;
  assign out_valid = (state == FULL);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      EMPTY: begin
        if (complete) begin
          state_nxt = FULL;
          load      = 1'b1;
        end
      end
      FULL: begin
        // A handshake frees the slot in the same edge a new total arrives.
        if (complete) begin
          if (out_ready) load = 1'b1;
          else           drop = 1'b1;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EMPTY;
      acc     <= '0;
      cnt     <= '0;
      acc_sat <= 1'b0;
      sum     <= '0;
      sat     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clr || (in_valid && last)) begin
        acc     <= '0;
        cnt     <= '0;
        acc_sat <= 1'b0;
      end else if (in_valid) begin
        acc     <= add_res;
        cnt     <= cnt + 6'd1;
        acc_sat <= win_sat;
      end
      if (load) begin
        sum <= add_res;
        sat <= win_sat;
      end
      if (drop) ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sum_window.sv
// Scoreboard bench for sum_window: a WIN=4 instance for the handshake, clear and
// reset scenarios, and a WIN=64 instance for the wrap/saturation boundary.
module tb_sum_window;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, clr, out_ready, out_valid, ovf, sat;
  logic [7:0]  x;
  logic [11:0] sum;
  logic        in_valid64, clr64, out_ready64, out_valid64, ovf64, sat64;
  logic [7:0]  x64;
  logic [11:0] sum64;

  int checks   = 0;
  int failures = 0;
  int q[$];
  int m_acc    = 0;
  int m_cnt    = 0;

  always #5 clk = ~clk;

  sum_window #(.WIN(4), .OW(12)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .ovf(ovf), .sat(sat)
  );

  sum_window #(.WIN(64), .OW(12)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .x(x64), .clr(clr64),
    .out_valid(out_valid64), .out_ready(out_ready64), .sum(sum64), .ovf(ovf64), .sat(sat64)
  );

  // Drive one sample and advance the model; a finished window pushes its total.
  task automatic send(input int v);
    in_valid = 1'b1;
    x        = 8'(v);
    clr      = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    m_acc += v;
    m_cnt++;
    if (m_cnt == 4) begin
      q.push_back(m_acc % 4096);
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0; x = '0;
    in_valid64 = 1'b0; clr64 = 1'b0; out_ready64 = 1'b0; x64 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    m_acc = 0; m_cnt = 0;
    q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({out_valid, sum, ovf, sat} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%0b sum=%0d ovf=%0b sat=%0b, want all 0",
               out_valid, sum, ovf, sat);
    end
    checks++;
    if ({out_valid64, sum64, ovf64, sat64} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs64: got valid=%0b sum=%0d ovf=%0b sat=%0b, want all 0",
               out_valid64, sum64, ovf64, sat64);
    end
  endtask

  task automatic test_basic_window();
    int exp;
    out_ready = 1'b1;
    send(10); send(20); send(30);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid: got %0b, want 0", out_valid);
    end
    send(40);
    exp = (q.size() > 0) ? q.pop_front() : -1;
    checks++;
    if (out_valid !== 1'b1 || int'(sum) != exp) begin
      failures++;
      $display("FAIL basic_sum: got valid=%0b sum=%0d, want valid=1 sum=%0d", out_valid, sum, exp);
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_one_cycle: got valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    int exp;
    out_ready = 1'b0;
    repeat (4) send(255);
    exp = (q.size() > 0) ? q.pop_front() : -1;
    checks++;
    if (out_valid !== 1'b1 || int'(sum) != exp || ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_first: got valid=%0b sum=%0d ovf=%0b, want 1/%0d/0", out_valid, sum, ovf, exp);
    end
    repeat (4) send(255);
    if (q.size() > 0) void'(q.pop_back());
    checks++;
    if (out_valid !== 1'b1 || int'(sum) != exp || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drop: got valid=%0b sum=%0d ovf=%0b, want 1/%0d/1", out_valid, sum, ovf, exp);
    end
    out_ready = 1'b1;
    idle(1);
    checks++;
    if (out_valid !== 1'b0 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_release: got valid=%0b ovf=%0b, want valid=0 ovf=1", out_valid, ovf);
    end
    apply_reset();
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_reset_clear: got %0b, want 0", ovf);
    end
  endtask

  task automatic test_back_to_back();
    int exp;
    out_ready = 1'b0;
    send(10); send(20); send(30); send(40);
    exp = (q.size() > 0) ? q.pop_front() : -1;
    checks++;
    if (out_valid !== 1'b1 || int'(sum) != exp) begin
      failures++;
      $display("FAIL b2b_first: got valid=%0b sum=%0d, want 1/%0d", out_valid, sum, exp);
    end
    send(1); send(1); send(1);
    out_ready = 1'b1;
    send(1);
    exp = (q.size() > 0) ? q.pop_front() : -1;
    checks++;
    if (out_valid !== 1'b1 || int'(sum) != exp || ovf !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: got valid=%0b sum=%0d ovf=%0b, want 1/%0d/0", out_valid, sum, ovf, exp);
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: got valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_clear();
    int exp;
    out_ready = 1'b1;
    send(5); send(5);
    in_valid = 1'b1; x = 8'd99; clr = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clr = 1'b0;
    m_acc = 0; m_cnt = 0;
    send(1); send(2); send(3);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL clr_early_valid: got %0b, want 0", out_valid);
    end
    send(4);
    exp = (q.size() > 0) ? q.pop_front() : -1;
    checks++;
    if (out_valid !== 1'b1 || int'(sum) != exp) begin
      failures++;
      $display("FAIL clr_sum: got valid=%0b sum=%0d, want 1/%0d", out_valid, sum, exp);
    end
    idle(1);
  endtask

  task automatic test_reset_mid_window();
    int exp;
    out_ready = 1'b0;
    repeat (4) send(7);
    exp = (q.size() > 0) ? q.pop_front() : -1;
    checks++;
    if (out_valid !== 1'b1 || int'(sum) != exp) begin
      failures++;
      $display("FAIL rstmid_pre: got valid=%0b sum=%0d, want 1/%0d", out_valid, sum, exp);
    end
    send(1); send(1); send(1);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, sum, ovf, sat} !== 15'd0) begin
      failures++;
      $display("FAIL rstmid_async: got valid=%0b sum=%0d ovf=%0b sat=%0b, want all 0",
               out_valid, sum, ovf, sat);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    m_acc = 0; m_cnt = 0;
    q.delete();
    out_ready = 1'b1;
    repeat (4) send(1);
    exp = (q.size() > 0) ? q.pop_front() : -1;
    checks++;
    if (out_valid !== 1'b1 || int'(sum) != exp) begin
      failures++;
      $display("FAIL rstmid_fresh: got valid=%0b sum=%0d, want 1/%0d", out_valid, sum, exp);
    end
    idle(1);
  endtask

  task automatic test_wide_window();
    int total = 0;
    int exp;
    int exp_sat;
    out_ready64 = 1'b1;
    clr64 = 1'b0;
    for (int i = 0; i < 64; i++) begin
      in_valid64 = 1'b1;
      x64 = 8'd255;
      total += 255;
      @(posedge clk); #1;
    end
    in_valid64 = 1'b0;
`ifdef SUM_WINDOW_SAT_EN
    exp     = (total > 4095) ? 4095 : total;
    exp_sat = (total > 4095) ? 1 : 0;
`else
    exp     = total % 4096;
    exp_sat = 0;
`endif
    checks++;
    if (out_valid64 !== 1'b1 || int'(sum64) != exp) begin
      failures++;
      $display("FAIL wide_sum: got valid=%0b sum=%0d, want 1/%0d", out_valid64, sum64, exp);
    end
    checks++;
    if (int'(sat64) != exp_sat) begin
      failures++;
      $display("FAIL wide_sat: got %0b, want %0d", sat64, exp_sat);
    end
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_reset_mid_window();
    test_wide_window();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sum_window.md
SUM_WINDOW -- requirements
Module: sum_window

Interface
REQ-001 Parameter WIN, default 4, is the samples per window; legal range 2..64.
REQ-002 Parameter OW, default 12, is the result width in bits.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset; state clears while rst=0.
REQ-005 Port in_valid, input, 1 bit: the x sample is valid this cycle. There is no in_ready; every valid sample is consumed.
REQ-006 Port x, input, 8 bits: sample from the upstream registered-sum stage.
REQ-007 Port clr, input, 1 bit: synchronous clear of the window in progress.
REQ-008 Port out_valid, output, 1 bit: sum holds an unaccepted result.
REQ-009 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 Port sum, output, OW bits: the window total.
REQ-011 Port ovf, output, 1 bit: sticky flag; a completed window was dropped.
REQ-012 Port sat, output, 1 bit: the current sum value was clipped (meaningful only with SUM_WINDOW_SAT_EN).

Function
REQ-013 The FSM has two states. EMPTY means the slot holds no result. FULL means the slot holds an unaccepted result. out_valid=1 exactly in FULL.
REQ-014 Accumulator acc is OW bits wide and cnt is 6 bits wide. Each cycle with in_valid=1: acc+=x and cnt+=1.
REQ-015 A window completes on the cycle where in_valid=1 and cnt==WIN-1. On the next edge, slot <= acc+x, acc <= 0 and cnt <= 0.
REQ-016 Latency: sum/out_valid update on the first edge after the last sample of the window is presented.
REQ-017 A handshake occurs when out_valid&&out_ready; at that edge the state moves FULL->EMPTY unless REQ-018 applies.
REQ-018 Completion in the same cycle as a handshake loads the new result; the state stays FULL and there is no gap.
REQ-019 Completion while FULL and out_ready=0 drops the new result. The slot is unchanged, ovf <= 1, and the window still restarts.
REQ-020 sum and sat stay stable while out_valid=1 and out_ready=0.
REQ-021 clr=1 zeroes acc and cnt; the sample presented in that cycle is discarded. The slot, out_valid and ovf are unaffected.
REQ-022 ovf clears only on reset.
REQ-023 Without SUM_WINDOW_SAT_EN, acc wraps modulo 2^OW.

Reset
REQ-024 While rst=0, the asynchronous reset forces: state=EMPTY, out_valid=0, sum=0, sat=0, ovf=0, acc=0, cnt=0.
REQ-025 Reset asserted mid-window discards the partial sum. The first valid sample after release starts a fresh window.

Configuration
REQ-026 Macro SUM_WINDOW_SAT_EN defined: acc saturates at 2^OW-1. The saturation flag is latched into sat together with the result.
REQ-027 Macro undefined: wrap-around arithmetic; sat is tied to 0.

Structure
REQ-028 Package sum_window_pkg holds the state enum {EMPTY, FULL}, the default constants WIN_DEF=4 and OW_DEF=12, and sample width DW=8.
REQ-029 Sub-module sat_add (OW-bit accumulator plus 8-bit sample) contains the only macro-dependent logic; the top FSM is macro-free.

Verification
REQ-030 WIN=4; samples 10,20,30,40 back-to-back; out_ready=1 -> one cycle after the 40, out_valid=1 and sum=100 for one cycle.
REQ-031 Hold out_ready=0; feed two windows of 4x255 -> sum=1020 held, ovf=1 after the second window. Then out_ready=1 -> out_valid=0 next cycle.
REQ-032 WIN=64; samples 64x255 -> with SUM_WINDOW_SAT_EN: sum=4095, sat=1. Without it: sum=16320 mod 4096=4032, sat=0.
REQ-033 Second window completes in the handshake cycle of the first -> out_valid stays 1 and sum changes 100->4 (samples 1,1,1,1); ovf=0.
REQ-034 Assert clr after 2 samples (5,5), then feed 1,2,3,4 -> sum=10.
REQ-035 Pull rst low after 3 samples, release, then feed 4x1 -> sum=4. Outputs read 0 while rst=0, asynchronously, without waiting for a clk edge.
